// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream handshake plus memory write ports and status of the program loader
//   in_valid/in_data/in_ready : host byte stream (host is master)
//   imem_we/dmem_we           : one-cycle write strobes into instruction / data memory
//   mem_waddr/mem_wdata       : shared word address and write data
//   cpu_hold/busy/load_done/err : CPU reset hold and loader status
interface prog_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              load_done;
  logic              err;
  modport master (output in_valid, in_data,
                  input in_ready, imem_we, dmem_we, mem_waddr, mem_wdata, cpu_hold, busy, load_done, err);
  modport slave  (input in_valid, in_data,
                  output in_ready, imem_we, dmem_we, mem_waddr, mem_wdata, cpu_hold, busy, load_done, err);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: parses framed load/run commands from a byte stream and writes words into IMEM/DMEM
//   clk, rst : clock and synchronous active-high reset
//   bus      : prog_loader_if.slave (byte stream in, memory write ports and status out)
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TGT, LEN0, LEN1, ADR0, ADR1, DATA, CSUM} state_t;
  state_t            state_q, state_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       addr_q, addr_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        xor_q, xor_d;
  logic              imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d, done_q, done_d, err_q, err_d, rdy_q;
  logic              acc;
  logic [7:0]        b;
  assign acc = bus.in_valid && rdy_q;
  assign b   = bus.in_data;
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    xor_d     = xor_q;
    imem_we_d = 1'b0;
    dmem_we_d = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = err_q;
    if (acc) begin
      case (state_q)
        IDLE: if (b == 8'hA5) begin
          state_d = TGT;
          xor_d   = 8'h00;
          bcnt_d  = 2'd0;
        end
        TGT: if (b > 8'h02) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tgt_d   = b[1:0];
          hold_d  = b[1] ? hold_q : 1'b1;
          state_d = LEN0;
        end
        LEN0: begin
          len_d   = {len_q[15:8], b};
          state_d = LEN1;
        end
        LEN1: begin
          len_d   = {b, len_q[7:0]};
          // a RUN frame carries no payload
          err_d   = err_q || (tgt_q == 2'd2 && {b, len_q[7:0]} != 16'd0);
          state_d = (tgt_q == 2'd2 && {b, len_q[7:0]} != 16'd0) ? IDLE : ADR0;
        end
        ADR0: begin
          addr_d  = {addr_q[15:8], b};
          state_d = ADR1;
        end
        ADR1: begin
          addr_d  = {b, addr_q[7:0]};
          state_d = (len_q == 16'd0) ? CSUM : DATA;
        end
        DATA: begin
          shift_d = {b, shift_q[31:8]};
          xor_d   = xor_q ^ b;
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wdata_d   = {b, shift_q[31:8]};
            waddr_d   = addr_q[ADDR_W-1:0];
            imem_we_d = (tgt_q == 2'd0);
            dmem_we_d = (tgt_q == 2'd1);
            // only the low ADDR_W bits are ever used, so the wrap is implicit
            addr_d    = addr_q + 16'd1;
            len_d     = len_q - 16'd1;
            state_d   = (len_q == 16'd1) ? CSUM : DATA;
          end
        end
        CSUM: begin
          state_d = IDLE;
          done_d  = (b == xor_q);
          err_d   = err_q || (b != xor_q);
          hold_d  = (b == xor_q && tgt_q == 2'd2) ? 1'b0 : hold_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tgt_q     <= 2'd0;
      len_q     <= 16'd0;
      addr_q    <= 16'd0;
      bcnt_q    <= 2'd0;
      shift_q   <= 32'd0;
      xor_q     <= 8'd0;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 32'd0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      xor_q     <= xor_d;
      imem_we_q <= imem_we_d;
      dmem_we_q <= dmem_we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdy_q     <= 1'b1;
    end
  end
  assign bus.in_ready  = rdy_q;
  assign bus.imem_we   = imem_we_q;
  assign bus.dmem_we   = dmem_we_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.load_done = done_q;
  assign bus.err       = err_q;
endmodule
